alu_32: RTL and testbench

- 32-bit, 8-operation ALU producing a result plus the four condition flags C, N, Z, V.
- Combinational datapath followed by one output register stage, clocked by clk and cleared by asynchronous active-low reset_n.
- Used as the execute-stage arithmetic/logic unit; flags feed downstream condition logic.

---
 rtl/alu_32_pkg.sv | 16 +
 rtl/alu_32_core.sv | 52 +++++
 rtl/alu_32.sv | 65 ++++++
 tb/tb_alu_32.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/alu_32_pkg.sv
// Shared constants for the alu_32 execute-stage ALU: datapath width and opcode map.
package alu_32_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned OP_W      = 3;

  localparam logic [OP_W-1:0] OP_NOTA = 3'b000;
  localparam logic [OP_W-1:0] OP_NOTB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
  localparam logic [OP_W-1:0] OP_ADD  = 3'b110;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b111;

endpackage

// File: rtl/alu_32_core.sv
// Combinational ALU core: op mux, shared adder/subtractor and C/N/Z/V flag generation.
module alu_32_core
  import alu_32_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [OP_W-1:0]  i_op,
  output logic [WIDTH-1:0] o_result_c,
  output logic             o_c_c,
  output logic             o_n_c,
  output logic             o_z_c,
  output logic             o_v_c
);

  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic             w_arith_v;

  // Subtraction reuses the adder as a + ~b + 1, so carry-out means "no borrow".
  assign w_sub     = (i_op == OP_SUB);
  assign w_b_eff   = w_sub ? ~i_b : i_b;
  assign w_sum     = {1'b0, i_a} + {1'b0, w_b_eff} + (WIDTH+1)'(w_sub);
  assign w_arith_v = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != i_a[WIDTH-1]);

  always_comb begin
    o_result_c = '0;
    o_c_c      = 1'b0;
    o_v_c      = 1'b0;
    case (i_op)
      OP_NOTA: o_result_c = ~i_a;
      OP_NOTB: o_result_c = ~i_b;
      OP_AND:  o_result_c = i_a & i_b;
      OP_OR:   o_result_c = i_a | i_b;
      OP_XOR:  o_result_c = i_a ^ i_b;
      OP_XNOR: o_result_c = ~(i_a ^ i_b);
      OP_ADD, OP_SUB: begin
        o_result_c = w_sum[WIDTH-1:0];
        o_c_c      = w_sum[WIDTH];
        o_v_c      = w_arith_v;
      end
      default: o_result_c = '0;
    endcase
  end

  assign o_n_c = o_result_c[WIDTH-1];
  assign o_z_c = (o_result_c == '0);

endmodule

// File: rtl/alu_32.sv
// Execute-stage ALU: combinational core followed by a single output register stage.
module alu_32
  import alu_32_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             c,
  output logic             n,
  output logic             z,
  output logic             v
);

  logic [WIDTH-1:0] w_result;
  logic             w_c;
  logic             w_n;
  logic             w_z;
  logic             w_v;

  logic [WIDTH-1:0] r_result;
  logic             r_c;
  logic             r_n;
  logic             r_z;
  logic             r_v;

  alu_32_core #(.WIDTH(WIDTH)) u_core (
    .i_a        (a),
    .i_b        (b),
    .i_op       (op),
    .o_result_c (w_result),
    .o_c_c      (w_c),
    .o_n_c      (w_n),
    .o_z_c      (w_z),
    .o_v_c      (w_v)
  );

  // Loads every cycle; reset clears the in-flight result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result <= '0;
      r_c      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
      r_v      <= 1'b0;
    end else begin
      r_result <= w_result;
      r_c      <= w_c;
      r_n      <= w_n;
      r_z      <= w_z;
      r_v      <= w_v;
    end
  end

  assign result = r_result;
  assign c      = r_c;
  assign n      = r_n;
  assign z      = r_z;
  assign v      = r_v;

endmodule

// File: tb/tb_alu_32.sv
// Self-checking bench for alu_32: directed vectors, pipelined sweep and mid-run reset.
module tb_alu_32;

  logic        clk;
  logic        reset_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op;
  logic [31:0] result;
  logic        c;
  logic        n;
  logic        z;
  logic        v;

  int checks = 0;
  int errors = 0;

  // Expected output packed as {result, c, n, z, v}
  logic [35:0] sb_q[$];
  string       tag_q[$];

  alu_32 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .a       (a),
    .b       (b),
    .op      (op),
    .result  (result),
    .c       (c),
    .n       (n),
    .z       (z),
    .v       (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [35:0] pk(input logic [31:0] r, input logic fc, input logic fn,
                                     input logic fz, input logic fv);
    return {r, fc, fn, fz, fv};
  endfunction

  // Reference model built from unsigned/signed integer arithmetic
  function automatic logic [35:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic [2:0] mop);
    logic [31:0] r;
    logic        fc;
    logic        fv;
    logic [32:0] s33;
    longint      ws;
    r  = 32'h0;
    fc = 1'b0;
    fv = 1'b0;
    case (mop)
      3'b000: r = ~ma;
      3'b001: r = ~mb;
      3'b010: r = ma & mb;
      3'b011: r = ma | mb;
      3'b100: r = ma ^ mb;
      3'b101: r = ~(ma ^ mb);
      3'b110: begin
        s33 = {1'b0, ma} + {1'b0, mb};
        r   = s33[31:0];
        fc  = s33[32];
        ws  = longint'($signed(ma)) + longint'($signed(mb));
        fv  = (ws > 64'sd2147483647) || (ws < -64'sd2147483648);
      end
      default: begin
        r  = ma - mb;
        fc = (ma >= mb);
        ws = longint'($signed(ma)) - longint'($signed(mb));
        fv = (ws > 64'sd2147483647) || (ws < -64'sd2147483648);
      end
    endcase
    return pk(r, fc, r[31], (r == 32'h0), fv);
  endfunction

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one transaction, push its expectation, then compare after the capturing edge
  task automatic step(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] top,
                      input logic [35:0] exp, input string tag);
    logic [35:0] e;
    string       t;
    a  = ta;
    b  = tb;
    op = top;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check(t, {result, c, n, z, v}, e);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  rop;

    reset_n = 1'b0;
    a  = 32'hDEADBEEF;
    b  = 32'h12345678;
    op = 3'b110;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_hold", {result, c, n, z, v}, 36'h0);

    #2 reset_n = 1'b1;
    step(32'h00000001, 32'h00000001, 3'b110, pk(32'h00000002, 0, 0, 0, 0), "add_1_1");
    step(32'hFFFFFFFF, 32'h00000001, 3'b110, pk(32'h00000000, 1, 0, 1, 0), "add_carry_zero");
    step(32'h7FFFFFFF, 32'h00000001, 3'b110, pk(32'h80000000, 0, 1, 0, 1), "add_ovf");
    step(32'h12345678, 32'h12345678, 3'b111, pk(32'h00000000, 1, 0, 1, 0), "sub_equal");
    step(32'h00000000, 32'h00000001, 3'b111, pk(32'hFFFFFFFF, 0, 1, 0, 0), "sub_borrow");
    step(32'h80000000, 32'h00000001, 3'b111, pk(32'h7FFFFFFF, 1, 0, 0, 1), "sub_ovf");

    step(32'hF0F0F0F0, 32'h0F0F00FF, 3'b000, pk(32'h0F0F0F0F, 0, 0, 0, 0), "nota");
    step(32'hF0F0F0F0, 32'h0F0F00FF, 3'b001, pk(32'hF0F0FF00, 0, 1, 0, 0), "notb");
    step(32'hF0F0F0F0, 32'h0F0F00FF, 3'b010, pk(32'h000000F0, 0, 0, 0, 0), "and");
    step(32'hF0F0F0F0, 32'h0F0F00FF, 3'b011, pk(32'hFFFFF0FF, 0, 1, 0, 0), "or");
    step(32'hF0F0F0F0, 32'h0F0F00FF, 3'b100, pk(32'hFFFFF00F, 0, 1, 0, 0), "xor");
    step(32'hF0F0F0F0, 32'h0F0F00FF, 3'b101, pk(32'h00000FF0, 0, 0, 0, 0), "xnor");
    step(32'h0F0F0F0F, 32'h0F0F0F0F, 3'b100, pk(32'h00000000, 0, 0, 1, 0), "xor_zero");

    // Op changes every cycle; each output must reflect the previous cycle's inputs
    for (int i = 0; i < 24; i++) begin
      ra  = $urandom;
      rb  = (i % 5 == 0) ? ra : $urandom;
      rop = 3'(i);
      step(ra, rb, rop, model(ra, rb, rop), "pipe");
    end

    // Asynchronous reset pulse between edges
    step(32'h40000000, 32'h40000000, 3'b110, pk(32'h80000000, 0, 1, 0, 1), "pre_reset");
    #2 reset_n = 1'b0;
    #1;
    check("reset_async_clear", {result, c, n, z, v}, 36'h0);
    sb_q.delete();
    tag_q.delete();
    a  = 32'hFFFFFFFF;
    b  = 32'hFFFFFFFF;
    op = 3'b110;
    @(posedge clk);
    #1;
    check("reset_held_edge", {result, c, n, z, v}, 36'h0);
    #2 reset_n = 1'b1;
    step(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110, pk(32'hFFFFFFFE, 1, 1, 0, 0), "post_reset");
    step(32'h00000005, 32'h00000007, 3'b111, pk(32'hFFFFFFFE, 0, 1, 0, 0), "post_reset_sub");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
